// File: rtl/piso_sched_pkg.sv
// Purpose : shared types and helpers for the PISO transmit scheduler.
//           Holds the FSM state encoding, its width, a ceiling-log2 helper
//           used to size grant_id and the bit counter, and the even-parity
//           helper used when the parity bit is enabled.
// Config  : PISO_PARITY_EN adds the PAR state and the parity helper.
package piso_sched_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
`ifdef PISO_PARITY_EN
    ST_SHIFT = 2'd2,
    ST_PAR   = 2'd3
`else
    ST_SHIFT = 2'd2
`endif
  } state_e;

  // Ceiling log2 for n >= 2 (number of bits to index n items).
  function automatic int clog2(input int n);
    int r;
    r = 32'sd0;
    for (int v = n - 32'sd1; v > 32'sd0; v = v >>> 1) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

`ifdef PISO_PARITY_EN
  // Even parity of a word of up to 16 bits (zero-extended by the caller).
  function automatic logic even_parity(input logic [15:0] w);
    return ^w;
  endfunction
`endif

endpackage

// File: rtl/piso_tx_scheduler_if.sv
// Purpose : requester-side bus of the PISO transmit scheduler.
// Signals : req      - per-requester request
//           data_in  - requester i word at [i*WIDTH +: WIDTH]
//           ack      - one-hot capture pulse
//           grant_id - index of the requester owning the shifter
//           busy     - scheduler not idle
//           s        - serial data, MSB first
//           s_valid  - s carries a valid bit
// Modports: master = requester/line side, slave = scheduler.
interface piso_tx_scheduler_if
  import piso_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) ();

  localparam int IDW = clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data_in;
  logic [NREQ-1:0]       ack;
  logic [IDW-1:0]        grant_id;
  logic                  busy;
  logic                  s;
  logic                  s_valid;

  modport master (
    output req, data_in,
    input  ack, grant_id, busy, s, s_valid
  );

  modport slave (
    input  req, data_in,
    output ack, grant_id, busy, s, s_valid
  );

endinterface

// File: rtl/piso_shifter.sv
// Purpose : WIDTH-bit parallel-in/serial-out register, MSB first.
// Ports   : clk, rst (async, active high)
//           load  - capture din (has priority over shift)
//           shift - shift left by one, zero fill
//           din   - parallel word
//           msb   - current most significant bit
module piso_shifter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] q_r;

  // Shift register: load wins over shift, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= '0;
    end else if (load) begin
      q_r <= din;
    end else if (shift) begin
      q_r <= {q_r[WIDTH-2:0], 1'b0};
    end else begin
      q_r <= q_r;
    end
  end

  assign msb = q_r[WIDTH-1];

endmodule

// File: rtl/piso_tx_scheduler.sv
// Purpose : round-robin scheduler sharing one PISO shifter among NREQ
//           requesters. Grants a requester, acks and loads its word, then
//           streams it MSB first with a valid strobe. All outputs registered.
// Ports   : clk, rst (async, active high), bus (piso_tx_scheduler_if.slave)
// Config  : PISO_PARITY_EN appends one even-parity bit per frame.
module piso_tx_scheduler
  import piso_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  piso_tx_scheduler_if.slave   bus
);

  localparam int IDW = clog2(NREQ);
  localparam int CW  = clog2(WIDTH);

  state_e           state_r, state_next_s;
  logic [IDW-1:0]   grant_r, grant_next_s;
  logic [IDW-1:0]   ptr_r, ptr_next_s;
  logic [IDW-1:0]   pick_s, idx_s;
  logic             found_s;
  logic [CW-1:0]    cnt_r, cnt_next_s;
  logic [NREQ-1:0]  ack_r, ack_next_s;
  logic             s_r, s_next_s;
  logic             s_valid_r, s_valid_next_s;
  logic             busy_r, busy_next_s;
  logic             load_s, shift_s, msb_s;
  logic [WIDTH-1:0] words_s [NREQ];
  logic [WIDTH-1:0] word_s;

  for (genvar g = 0; g < NREQ; g++) begin : g_words
    assign words_s[g] = bus.data_in[g*WIDTH +: WIDTH];
  end
  assign word_s = words_s[grant_r];

  piso_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .load  (load_s),
    .shift (shift_s),
    .din   (word_s),
    .msb   (msb_s)
  );

`ifdef PISO_PARITY_EN
  logic parity_r;

  // Parity of the word captured at the LOAD closing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_r <= 1'b0;
    end else if (load_s) begin
      parity_r <= even_parity(16'(word_s));
    end else begin
      parity_r <= parity_r;
    end
  end
`endif

  // Round-robin search: first request after the last served requester.
  always_comb begin
    pick_s  = grant_r;
    found_s = 1'b0;
    idx_s   = '0;
    for (int i = 32'sd1; i <= NREQ; i++) begin
      idx_s = IDW'((int'(ptr_r) + i) % NREQ);
      if (!found_s && bus.req[idx_s]) begin
        pick_s  = idx_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    state_next_s   = state_r;
    grant_next_s   = grant_r;
    ptr_next_s     = ptr_r;
    cnt_next_s     = cnt_r;
    ack_next_s     = '0;
    s_next_s       = 1'b0;
    s_valid_next_s = 1'b0;
    load_s         = 1'b0;
    shift_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (|bus.req) begin
          grant_next_s = pick_s;
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // A withdrawn request abandons the grant without moving the pointer.
        if (bus.req[grant_r]) begin
          ack_next_s[grant_r] = 1'b1;
          load_s              = 1'b1;
          ptr_next_s          = grant_r;
          cnt_next_s          = '0;
          state_next_s        = ST_SHIFT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        s_next_s       = msb_s;
        s_valid_next_s = 1'b1;
        shift_s        = 1'b1;
        if (cnt_r == CW'(WIDTH - 1)) begin
          cnt_next_s = '0;
`ifdef PISO_PARITY_EN
          state_next_s = ST_PAR;
`else
          state_next_s = ST_IDLE;
`endif
        end else begin
          cnt_next_s = cnt_r + CW'(1);
        end
      end
`ifdef PISO_PARITY_EN
      ST_PAR: begin
        s_next_s       = parity_r;
        s_valid_next_s = 1'b1;
        state_next_s   = ST_IDLE;
      end
`endif
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
    // busy also covers the final bit, which leaves the register after the FSM is idle.
    busy_next_s = (state_next_s != ST_IDLE) || s_valid_next_s;
  end

  // State, arbitration and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      grant_r   <= '0;
      ptr_r     <= IDW'(NREQ - 1);
      cnt_r     <= '0;
      ack_r     <= '0;
      s_r       <= 1'b0;
      s_valid_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      grant_r   <= grant_next_s;
      ptr_r     <= ptr_next_s;
      cnt_r     <= cnt_next_s;
      ack_r     <= ack_next_s;
      s_r       <= s_next_s;
      s_valid_r <= s_valid_next_s;
      busy_r    <= busy_next_s;
    end
  end

  assign bus.ack      = ack_r;
  assign bus.grant_id = grant_r;
  assign bus.busy     = busy_r;
  assign bus.s        = s_r;
  assign bus.s_valid  = s_valid_r;

endmodule
